// File: rtl/falafel_pkg.sv
// falafel_pkg
//   Shared constants for the falafel allocator datapath.
//   DATA_W : width of one response word.
package falafel_pkg;

  parameter int DATA_W = 64;

endpackage

// File: rtl/falafel_resp_fifo.sv
// falafel_resp_fifo
//   Response FIFO between the allocator core and the response output stage.
//   The core pushes one word per accepted push. The output stage reads through
//   a show-ahead port: the head word is visible on resp_fifo_dout_o whenever the
//   FIFO holds data, and a read strobe consumes it at the next clock edge.
//   An occupancy count gives the core back-pressure, and two sticky flags
//   record overflow/underflow attempts for debug.
//
// Ports
//   clk_i              : clock, all state changes on the rising edge
//   rst_i              : synchronous active-high reset
//   push_i             : write strobe from the core
//   push_data_i        : word to enqueue
//   resp_fifo_full_o   : count == DEPTH
//   resp_fifo_read_i   : pop strobe from the output stage
//   resp_fifo_empty_o  : count == 0
//   resp_fifo_dout_o   : head word, '0 when empty
//   usage_o            : current occupancy, 0..DEPTH
//   ovf_o              : sticky, a push was attempted while full
//   udf_o              : sticky, a read was attempted while empty
//
// Handshake semantics
//   Write side: push_i acts as "valid" and !resp_fifo_full_o as "ready"; a word
//   transfers on a rising edge where both are high. Read side:
//   !resp_fifo_empty_o acts as "valid" and resp_fifo_read_i as "ready"; the head
//   word is consumed on a rising edge where both are high. A strobe raised
//   while its partner is low is dropped and only sets the matching sticky
//   error flag. Both full and empty come from registered state only, so
//   neither strobe has a combinational path to any output.
//
// Parameter constraints
//   DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
module falafel_resp_fifo #(
  parameter int DATA_W = falafel_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              resp_fifo_full_o,
  input  logic              resp_fifo_read_i,
  output logic              resp_fifo_empty_o,
  output logic [DATA_W-1:0] resp_fifo_dout_o,
  output logic [CNT_W-1:0]  usage_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // Storage and bookkeeping
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf_q;
  logic              udf_q;

  // Decoded status and accept strobes
  logic full;
  logic empty;
  logic push_acc;
  logic pop_acc;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is dropped even if a pop frees a slot in the same
  // cycle; full is taken from the registered count, never from the pop.
  assign push_acc = push_i && !full;
  assign pop_acc  = resp_fifo_read_i && !empty;

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      // Simultaneous push and pop leave the count unchanged.
      unique case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (push_i && full) begin
        ovf_q <= 1'b1;
      end
      if (resp_fifo_read_i && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  // Memory array is not reset; stale contents are never visible because the
  // output is forced to zero while empty. A push in the reset cycle is ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_acc) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // Show-ahead read port. There is no bypass from push_data_i: a word pushed
  // into an empty FIFO appears one cycle later.
  always_comb begin
    resp_fifo_dout_o = '0;
    if (!empty) begin
      resp_fifo_dout_o = mem[rd_ptr];
    end
  end

  assign resp_fifo_full_o  = full;
  assign resp_fifo_empty_o = empty;
  assign usage_o           = count;
  assign ovf_o             = ovf_q;
  assign udf_o             = udf_q;

endmodule
